// File: rtl/pulse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_pkg
//  Description : Shared types and helpers for the pulse period checker:
//                FSM state encoding and the gap-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pulse_pkg;

    // Two-bit state encoding; the fourth code point is illegal and recovers to idle.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'h0,
        ST_ACQUIRE = 2'h1,
        ST_LOCKED  = 2'h2
    } state_t;

    // The gap counter must hold values 0..PERIOD+1.
    function automatic int gap_width(input int period);
        return $clog2(period + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_period_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_period_checker_if
//  Description : Bundles the pulse stream under test, the error-clear input
//                and the lock/error status outputs of the checker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pulse_period_checker_if
    import pulse_pkg::*;
#(
    parameter int PERIOD = 4,
    parameter int ERR_W  = 8
);
    localparam int GW = gap_width(PERIOD);

    logic             pulse_in;
    logic             clr_err;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic [GW-1:0]    phase;

    // Stimulus / consumer side.
    modport master (
        output pulse_in,
        output clr_err,
        input  locked,
        input  err_pulse,
        input  err_cnt,
        input  phase
    );

    // Checker side.
    modport slave (
        input  pulse_in,
        input  clr_err,
        output locked,
        output err_pulse,
        output err_cnt,
        output phase
    );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at its all-ones value; a clear takes
//                priority over a simultaneous increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         inc,
    input  wire logic         clr,
    output logic      [W-1:0] count
);
    localparam logic [W-1:0] C_MAX = '1;
    localparam logic [W-1:0] C_ONE = W'(1);

    // Count increments, holding at the maximum; clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != C_MAX)) begin
            count <= count + C_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pulse_period_checker.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_period_checker
//  Description : Monitors a periodic one-cycle pulse stream. Locks after
//                LOCK_COUNT consecutive correctly spaced pulses, then reports
//                missing or early pulses with a strobe and a saturating count.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_period_checker
    import pulse_pkg::*;
#(
    parameter int PERIOD     = 4,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_W      = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    pulse_period_checker_if.slave bus
);
    localparam int GW = gap_width(PERIOD);
    localparam int CW = $clog2(LOCK_COUNT + 1);

    localparam logic [GW-1:0] C_GAP_ONE   = GW'(1);
    localparam logic [GW-1:0] C_PERIOD    = GW'(PERIOD);
    localparam logic [GW-1:0] C_GAP_SAT   = GW'(PERIOD + 1);
    localparam logic [CW:0]   C_GOOD_ONE  = (CW + 1)'(1);
    localparam logic [CW:0]   C_LOCK_TGT  = (CW + 1)'(LOCK_COUNT);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_gap;
    logic [CW-1:0]   r_good;
    logic [CW-1:0]   w_good_nxt;
    logic [CW:0]     w_good_inc;
    logic            w_good;
    logic            w_early;
    logic            w_miss;
    logic            w_err;
    logic            r_err_pulse;

    // Cycles since the last pulse: restarts at 1 on a pulse, sticks at PERIOD+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap <= '0;
        end else if (bus.pulse_in) begin
            r_gap <= C_GAP_ONE;
        end else if (r_gap != C_GAP_SAT) begin
            r_gap <= r_gap + C_GAP_ONE;
        end
    end

    // Every pulse that is not exactly on time is early, including the
    // trailing cycles of a pulse held high.
    assign w_good     = bus.pulse_in  && (r_gap == C_PERIOD);
    assign w_early    = bus.pulse_in  && (r_gap != C_PERIOD);
    assign w_miss     = !bus.pulse_in && (r_gap == C_PERIOD);
    assign w_good_inc = {1'b0, r_good} + C_GOOD_ONE;

    // State and good-period counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_good  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
        end
    end

    // Next-state logic; errors are only raised while locked.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.pulse_in) begin
                    w_state_nxt = ST_ACQUIRE;
                    w_good_nxt  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (w_good) begin
                    if (w_good_inc == C_LOCK_TGT) begin
                        w_state_nxt = ST_LOCKED;
                        w_good_nxt  = '0;
                    end else begin
                        w_good_nxt  = w_good_inc[CW-1:0];
                    end
                end else if (w_early) begin
                    // The early pulse becomes the new phase reference.
                    w_good_nxt = '0;
                end else if (w_miss) begin
                    w_state_nxt = ST_IDLE;
                    w_good_nxt  = '0;
                end
            end
            ST_LOCKED: begin
                if (w_early) begin
                    w_state_nxt = ST_ACQUIRE;
                    w_good_nxt  = '0;
                    w_err       = 1'b1;
                end else if (w_miss) begin
                    w_state_nxt = ST_IDLE;
                    w_good_nxt  = '0;
                    w_err       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_good_nxt  = '0;
            end
        endcase
    end

    // One-cycle error strobe, registered so it appears the cycle after detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_err;
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_err),
        .clr   (bus.clr_err),
        .count (bus.err_cnt)
    );

    assign bus.locked    = (r_state == ST_LOCKED);
    assign bus.err_pulse = r_err_pulse;
    assign bus.phase     = (r_state == ST_LOCKED) ? r_gap : '0;

endmodule
`default_nettype wire
